fetch_queue_unit: RTL

//  Parametrised instruction-fetch stage for the 5-stage MIPS pipeline.
//  - Replaces the fixed PC + IF/ID register pair with a PC generator feeding a DEPTH-entry prefetch queue.
//  - Decode consumes through a valid/ready handshake, replacing the old PCWrite/IFIDWrite stall pair.
//  - Redirects from branch, jump or jr resolution flush the queue and restart fetch at the target.

---
 rtl/fetch_queue_unit_pkg.sv | 19 +
 rtl/fetch_queue_unit_sync_fifo.sv | 55 +++++
 rtl/fetch_queue_unit.sv | 91 +++++++++
 3 files changed

// File: rtl/fetch_queue_unit_pkg.sv
// Shared constants, entry type and helpers for the instruction-fetch queue.
package fetch_queue_unit_pkg;

  localparam int                  DEF_XLEN     = 32;
  localparam int                  DEF_DEPTH    = 4;
  localparam logic [DEF_XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [DEF_XLEN-1:0] DEF_NOP      = 32'h0000_0000;

  typedef struct packed {
    logic [DEF_XLEN-1:0] instr;
    logic [DEF_XLEN-1:0] pcplus4;
  } fetch_entry_t;

  // Stall counter must stick at all-ones rather than wrap back to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/fetch_queue_unit_sync_fifo.sv
// DEPTH x W prefetch storage with natural-wrap pointers, occupancy and a flush
// that dominates any same-cycle push or pop.
module fetch_queue_unit_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   occ_r;

  // Pointer and occupancy bookkeeping; flush returns everything to the empty state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      occ_r    <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      occ_r    <= {(AW+1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      occ_r <= occ_r + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Entry storage; stale slots are harmless because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign rdata     = mem_r[rd_ptr_r];
  assign occupancy = occ_r;

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: PC generator feeding a prefetch queue drained by decode via
// valid/ready, with redirect flush and a full-queue stall counter.
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int               DEPTH    = DEF_DEPTH,
  parameter int               XLEN     = DEF_XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = DEF_RESET_PC,
  parameter logic [XLEN-1:0]  NOP      = DEF_NOP
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [XLEN-1:0]         imem_addr,
  input  logic [XLEN-1:0]         imem_rdata,
  output logic                    id_valid,
  input  logic                    id_ready,
  output logic [XLEN-1:0]         id_instr,
  output logic [XLEN-1:0]         id_pcplus4,
  input  logic                    redirect,
  input  logic [XLEN-1:0]         redirect_pc,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic [31:0]             stall_cnt
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_C = (AW+1)'(DEPTH);

  logic [XLEN-1:0]   pc_r;
  logic [XLEN-1:0]   pc_nxt_s;
  logic [XLEN-1:0]   pc_plus4_s;
  logic [31:0]       stall_cnt_r;
  logic [AW:0]       occ_s;
  logic [2*XLEN-1:0] head_s;
  logic              valid_s;
  logic              pop_s;
  logic              room_s;
  logic              push_s;

  assign valid_s    = (occ_s != {(AW+1){1'b0}});
  assign pop_s      = valid_s & id_ready;
  assign room_s     = (occ_s < DEPTH_C) | pop_s;
  assign push_s     = room_s & ~redirect;
  assign pc_plus4_s = pc_r + XLEN'(4);

  // Next PC: redirect target (word aligned) beats sequential fetch; a full queue holds.
  always_comb begin
    pc_nxt_s = pc_r;
    if (redirect) begin
      pc_nxt_s = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (push_s) begin
      pc_nxt_s = pc_plus4_s;
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // PC register and stall counter; a redirect cycle is never counted as a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r        <= RESET_PC;
      stall_cnt_r <= 32'd0;
    end else begin
      pc_r <= pc_nxt_s;
      if (!redirect && !push_s) begin
        stall_cnt_r <= sat_inc32(stall_cnt_r);
      end
    end
  end

  fetch_queue_unit_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (2*XLEN)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push_s),
    .pop       (pop_s),
    .wdata     ({imem_rdata, pc_plus4_s}),
    .rdata     (head_s),
    .occupancy (occ_s)
  );

  assign imem_addr  = pc_r;
  assign id_valid   = valid_s;
  assign id_instr   = valid_s ? head_s[2*XLEN-1:XLEN] : NOP;
  assign id_pcplus4 = valid_s ? head_s[XLEN-1:0] : {XLEN{1'b0}};
  assign occupancy  = occ_s;
  assign stall_cnt  = stall_cnt_r;

endmodule
